// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory req/ready port for loads and stores,
// steers byte lanes, extends load data, and resolves the branch/jump redirect.
module mem_stage #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned NUM_WORDS      = 1024,
    parameter int unsigned ADDR_SIZE      = $clog2(NUM_WORDS),
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           data_size,
    input  logic                 data_sign,
    input  logic                 branch,
    input  logic                 alu_zero,
    input  logic                 jump,
    input  logic [ADDR_SIZE-1:0] branch_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_ready,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] load_data_out,
    output logic                 misalign_err,
    output logic                 bus_err,
    output logic                 pc_src,
    output logic [ADDR_SIZE-1:0] pc_target
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;

    logic                req_d, we_d, bus_err_d;
    logic [ADDR_SIZE-1:0] addr_d;
    logic [WORD_SIZE-1:0] wdata_d, ld_d;
    logic [3:0]          be_d;

    logic                access, aligned, start;
    logic [WORD_SIZE-1:0] st_wdata, ld_fmt;
    logic [3:0]          st_be;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;

    logic unused_addr_bits;
    assign unused_addr_bits = ^alu_result[WORD_SIZE-1:ADDR_SIZE+2];

    assign pc_src    = (branch & alu_zero) | jump;
    assign pc_target = branch_target;

    always_comb begin
        access = mem_read | mem_write;
        unique case (data_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_result[0];
            2'b10:   aligned = (alu_result[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        start        = access & aligned & (state_q == StIdle);
        misalign_err = access & ~aligned & (state_q == StIdle);
        stall        = start | (state_q == StWait);
    end

    // Store lane replication and byte enables
    always_comb begin
        st_wdata = write_data;
        st_be    = 4'b1111;
        unique case (data_size)
            2'b00: begin
                st_wdata = {4{write_data[7:0]}};
                st_be    = 4'(4'b0001 << alu_result[1:0]);
            end
            2'b01: begin
                st_wdata = {2{write_data[15:0]}};
                st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = write_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension, using the fields latched at request time
    always_comb begin
        ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_fmt = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        size_d    = size_q;
        sign_d    = sign_q;
        req_d     = dmem_req;
        we_d      = dmem_we;
        addr_d    = dmem_addr;
        wdata_d   = dmem_wdata;
        be_d      = dmem_be;
        ld_d      = load_data_out;
        bus_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = alu_result[ADDR_SIZE+1:2];
                    wdata_d = st_wdata;
                    be_d    = mem_write ? st_be : 4'b0000;
                    off_d   = alu_result[1:0];
                    size_d  = data_size;
                    sign_d  = data_sign;
                end
            end
            StWait: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (!dmem_we) begin
                        ld_d = ld_fmt;
                    end
                end else if (cnt_q == CntLast) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    ld_d      = '0;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            off_q         <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            load_data_out <= '0;
            bus_err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            off_q         <= off_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            dmem_req      <= req_d;
            dmem_we       <= we_d;
            dmem_addr     <= addr_d;
            dmem_wdata    <= wdata_d;
            dmem_be       <= be_d;
            load_data_out <= ld_d;
            bus_err       <= bus_err_d;
        end
    end

endmodule
